// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic array feeder.
// Holds the feeder state encoding, the default operand width and a one-hot helper.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_t;

    localparam int unsigned DATA_W_DEFAULT = 8;

    // Widest row select the helper can produce; callers truncate to N.
    localparam int unsigned ONEHOT_W = 32;

    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake and array-edge bus of the systolic feeder.
// bubble_count exists only when FEEDER_BUBBLE_STATS_EN is defined.
interface systolic_feeder_if #(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);
    logic                  start;
    logic [CNT_W-1:0]      num_vectors;
    logic                  w_valid;
    logic                  w_ready;
    logic [N*DATA_W-1:0]   w_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DATA_W-1:0]   in_data;
    logic [N*DATA_W-1:0]   weight_out;
    logic [N-1:0]          load_weight;
    logic [N*DATA_W-1:0]   a_out;
    logic [N-1:0]          valid_out;
    logic                  busy;
    logic                  done;
`ifdef FEEDER_BUBBLE_STATS_EN
    logic [15:0]           bubble_count;

    modport master (
        output start, num_vectors, w_valid, w_data, in_valid, in_data,
        input  w_ready, in_ready, weight_out, load_weight, a_out, valid_out,
        input  busy, done, bubble_count
    );
    modport slave (
        input  start, num_vectors, w_valid, w_data, in_valid, in_data,
        output w_ready, in_ready, weight_out, load_weight, a_out, valid_out,
        output busy, done, bubble_count
    );
`else
    modport master (
        output start, num_vectors, w_valid, w_data, in_valid, in_data,
        input  w_ready, in_ready, weight_out, load_weight, a_out, valid_out,
        input  busy, done
    );
    modport slave (
        input  start, num_vectors, w_valid, w_data, in_valid, in_data,
        output w_ready, in_ready, weight_out, load_weight, a_out, valid_out,
        output busy, done
    );
`endif
endinterface

// File: rtl/skew_delay_line.sv
// Fixed-latency {valid, data} delay: DEPTH skew stages plus one output register.
module skew_delay_line #(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int unsigned STAGES = DEPTH + 1;

    logic [WIDTH:0] r_pipe [STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= {i_valid, i_data};
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {o_valid, o_data} = r_pipe[STAGES-1];

endmodule

// File: rtl/systolic_feeder.sv
// Weight loader and skewed activation streamer for an N x N weight-stationary array.
// Optional bubble statistics are compiled in with FEEDER_BUBBLE_STATS_EN.
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    systolic_feeder_if.slave bus
);
    localparam int unsigned ROW_W = $clog2(N) + 1;
    localparam int unsigned VEC_W = N * DATA_W;

    feeder_state_t    r_state;
    logic [ROW_W-1:0] r_row_cnt;
    logic [ROW_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_num_vectors;
    logic [VEC_W-1:0] r_weight_out;
    logic [N-1:0]     r_load_weight;
    logic             r_w_ready;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_w_beat;
    logic             w_in_beat;
    logic             w_last_row;
    logic             w_last_vec;
    logic [VEC_W-1:0] w_inj_data;
    logic [VEC_W-1:0] w_a_out;
    logic [N-1:0]     w_valid_out;

    assign w_w_beat   = (r_state == LOAD_W) && r_w_ready && bus.w_valid;
    assign w_in_beat  = (r_state == STREAM) && r_in_ready && bus.in_valid;
    assign w_last_row = (r_row_cnt == ROW_W'(N - 1));
    // STREAM is only entered with num_vectors >= 1, so the subtraction cannot underflow.
    assign w_last_vec = (r_vec_cnt == (r_num_vectors - CNT_W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_row_cnt     <= '0;
            r_drain_cnt   <= '0;
            r_vec_cnt     <= '0;
            r_num_vectors <= '0;
            r_weight_out  <= '0;
            r_load_weight <= '0;
            r_w_ready     <= 1'b0;
            r_in_ready    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_load_weight <= '0;
            r_done        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_num_vectors <= bus.num_vectors;
                        r_row_cnt     <= '0;
                        r_drain_cnt   <= '0;
                        r_vec_cnt     <= '0;
                        r_w_ready     <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_w_beat) begin
                        r_weight_out  <= bus.w_data;
                        r_load_weight <= N'(onehot(32'(r_row_cnt)));
                        r_row_cnt     <= r_row_cnt + ROW_W'(1);
                        if (w_last_row) begin
                            r_w_ready <= 1'b0;
                            if (r_num_vectors == '0) begin
                                r_state <= DRAIN;
                            end else begin
                                r_in_ready <= 1'b1;
                                r_state    <= STREAM;
                            end
                        end
                    end
                end
                STREAM: begin
                    if (w_in_beat) begin
                        r_vec_cnt <= r_vec_cnt + CNT_W'(1);
                        if (w_last_vec) begin
                            r_in_ready <= 1'b0;
                            r_state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Row N-1 of the final vector leaves the skew lines on the N-th drain cycle.
                    r_drain_cnt <= r_drain_cnt + ROW_W'(1);
                    if (r_drain_cnt == ROW_W'(N - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Non-transfer cycles inject zero bubbles so every wavefront stays aligned.
    assign w_inj_data = w_in_beat ? bus.in_data : '0;

    for (genvar gr = 0; gr < N; gr++) begin : g_row
        skew_delay_line #(
            .DEPTH (gr),
            .WIDTH (DATA_W)
        ) u_skew (
            .clk     (clk),
            .reset   (reset),
            .i_valid (w_in_beat),
            .i_data  (w_inj_data[gr*DATA_W +: DATA_W]),
            .o_valid (w_valid_out[gr]),
            .o_data  (w_a_out[gr*DATA_W +: DATA_W])
        );
    end

`ifdef FEEDER_BUBBLE_STATS_EN
    logic [15:0] r_bubble_count;

    // Counts stalled STREAM cycles where the feeder was ready but no vector arrived.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bubble_count <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_bubble_count <= '0;
        end else if ((r_state == STREAM) && r_in_ready && !bus.in_valid
                     && (r_bubble_count != 16'hFFFF)) begin
            r_bubble_count <= r_bubble_count + 16'd1;
        end
    end

    assign bus.bubble_count = r_bubble_count;
`endif

    assign bus.w_ready     = r_w_ready;
    assign bus.in_ready    = r_in_ready;
    assign bus.weight_out  = r_weight_out;
    assign bus.load_weight = r_load_weight;
    assign bus.a_out       = w_a_out;
    assign bus.valid_out   = w_valid_out;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: a cycle-indexed timeline model of each job
// (accepted vectors keyed by cycle) predicts every output; FEEDER_BUBBLE_STATS_EN adds bubble checks.
module tb_systolic_feeder;
    localparam int unsigned N  = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned VW = N * DW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .DATA_W(DW), .CNT_W(CW)) bus ();

    systolic_feeder #(.N(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit          use_fix_w = 1'b0;
    logic [VW-1:0] fix_w [N];
    logic [VW-1:0] fix_v [$];
    bit          vpat [$];

    // Runs one job starting in the current cycle (called #1 after a posedge).
    // Timeline relative to the start cycle 0: weight beats in 1..N, stream from N+1,
    // done N+1 cycles after the last accepted vector. lat returns the observed done cycle.
    task automatic run_job(input int num, input int gap_pct, input bit poke, output int lat);
        logic [VW-1:0] wrow [N];
        logic [VW-1:0] acc [int];
        logic [VW-1:0] exp_a;
        logic [VW-1:0] tmp;
        logic [N-1:0]  exp_v;
        logic [N-1:0]  exp_lw;
        int nacc = 0;
        int last = -1;
        int bubbles = 0;
        int dn;
        bit rdy, wr, bz, ended;
        lat = -1;
        ended = 1'b0;
        for (int i = 0; i < N; i++) wrow[i] = use_fix_w ? fix_w[i] : VW'($urandom);
        bus.start = 1'b1;
        bus.num_vectors = CW'(num);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.num_vectors = CW'($urandom);
        if (num == 0) last = N;
        for (int c = 1; c < 2000; c++) begin
            wr  = (c <= N);
            rdy = (c > N) && (nacc < num);
            bus.w_valid = 1'b1;
            bus.w_data  = (c <= N) ? wrow[c-1] : VW'($urandom);
            if (rdy) bus.in_valid = (vpat.size() > 0) ? vpat.pop_front() : ($urandom_range(99) >= gap_pct);
            else     bus.in_valid = 1'($urandom_range(1));
            if (rdy && bus.in_valid && fix_v.size() > 0) bus.in_data = fix_v.pop_front();
            else bus.in_data = VW'($urandom);
            bus.start = poke && rdy && (nacc == 0);
            if (poke) bus.num_vectors = CW'(num + 3);
            if (rdy && bus.in_valid) begin
                acc[c] = bus.in_data;
                nacc++;
                if (nacc == num) last = c;
            end
            if (rdy && !bus.in_valid) bubbles++;
            dn = (last < 0) ? -1 : last + N + 1;
            bz = (dn < 0) || (c < dn);
            exp_lw = '0;
            if (c >= 2 && c <= N + 1) exp_lw = N'(1) << (c - 2);
            for (int r = 0; r < N; r++) begin
                exp_v[r] = acc.exists(c - r - 1);
                tmp = exp_v[r] ? acc[c - r - 1] : '0;
                exp_a[r*DW +: DW] = tmp[r*DW +: DW];
            end
            #4;
            checks += 7;
            if (bus.w_ready !== wr) begin errors++; $display("FAIL w_ready c=%0d got %b exp %b", c, bus.w_ready, wr); end
            if (bus.in_ready !== rdy) begin errors++; $display("FAIL in_ready c=%0d got %b exp %b", c, bus.in_ready, rdy); end
            if (bus.busy !== bz) begin errors++; $display("FAIL busy c=%0d got %b exp %b", c, bus.busy, bz); end
            if (bus.done !== (c == dn)) begin errors++; $display("FAIL done c=%0d got %b exp %b", c, bus.done, (c == dn)); end
            if (bus.load_weight !== exp_lw) begin errors++; $display("FAIL load_weight c=%0d got %b exp %b", c, bus.load_weight, exp_lw); end
            if (bus.valid_out !== exp_v) begin errors++; $display("FAIL valid_out c=%0d got %b exp %b", c, bus.valid_out, exp_v); end
            if (bus.a_out !== exp_a) begin errors++; $display("FAIL a_out c=%0d got %h exp %h", c, bus.a_out, exp_a); end
            if (exp_lw != '0) begin
                checks++;
                if (bus.weight_out !== wrow[c-2]) begin
                    errors++; $display("FAIL weight_out c=%0d got %h exp %h", c, bus.weight_out, wrow[c-2]);
                end
            end
            if (bus.done === 1'b1 && lat < 0) lat = c;
            if (c == dn) begin ended = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ended) begin errors++; $display("FAIL job_timeout got running exp done by cycle %0d", dn); end
`ifdef FEEDER_BUBBLE_STATS_EN
        checks++;
        if (bus.bubble_count !== 16'(bubbles)) begin
            errors++; $display("FAIL bubble_count got %0d exp %0d", bus.bubble_count, bubbles);
        end
`endif
        bus.start = 1'b0;
        fix_v.delete();
        vpat.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        checks += 8;
        if (bus.w_ready !== 1'b0) begin errors++; $display("FAIL %s w_ready got %b exp 0", tag, bus.w_ready); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready got %b exp 0", tag, bus.in_ready); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b exp 0", tag, bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done got %b exp 0", tag, bus.done); end
        if (bus.load_weight !== '0) begin errors++; $display("FAIL %s load_weight got %b exp 0", tag, bus.load_weight); end
        if (bus.weight_out !== '0) begin errors++; $display("FAIL %s weight_out got %h exp 0", tag, bus.weight_out); end
        if (bus.valid_out !== '0) begin errors++; $display("FAIL %s valid_out got %b exp 0", tag, bus.valid_out); end
        if (bus.a_out !== '0) begin errors++; $display("FAIL %s a_out got %h exp 0", tag, bus.a_out); end
`ifdef FEEDER_BUBBLE_STATS_EN
        checks++;
        if (bus.bubble_count !== 16'd0) begin errors++; $display("FAIL %s bubble_count got %0d exp 0", tag, bus.bubble_count); end
`endif
    endtask

    task automatic test_reset;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_directed;
        int lat;
        use_fix_w = 1'b1;
        fix_w[0] = 16'h0503;
        fix_w[1] = 16'h0207;
        fix_v = '{16'h0401, 16'h0602};
        vpat = '{1'b1, 1'b1};
        run_job(2, 0, 1'b0, lat);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL directed_done_cycle got %0d exp 7", lat); end
    endtask

    task automatic test_gap;
        int lat;
        fix_w[0] = 16'h0503;
        fix_w[1] = 16'h0207;
        fix_v = '{16'h0401, 16'h0602};
        vpat = '{1'b1, 1'b0, 1'b1};
        run_job(2, 0, 1'b0, lat);
        use_fix_w = 1'b0;
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL gap_done_cycle got %0d exp 8", lat); end
    endtask

    task automatic test_zero_vectors;
        int lat;
        run_job(0, 0, 1'b0, lat);
        checks++;
        if (lat !== 2 * N + 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp %0d", lat, 2 * N + 1); end
    endtask

    task automatic test_start_ignored;
        int lat;
        run_job(3, 0, 1'b1, lat);
        checks++;
        if (lat !== 3 + 2 * N + 1) begin errors++; $display("FAIL poke_done_cycle got %0d exp %0d", lat, 3 + 2 * N + 1); end
    endtask

    task automatic test_back_to_back;
        int lat;
        for (int j = 0; j < 5; j++) run_job(int'($urandom_range(10, 1)), 30, 1'b0, lat);
    endtask

    task automatic test_max_vectors;
        int lat;
        run_job(255, 10, 1'b0, lat);
    endtask

    task automatic test_reset_mid_stream;
        int lat;
        bus.start = 1'b1;
        bus.num_vectors = 8'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.w_valid = 1'b1;
        bus.in_valid = 1'b1;
        repeat (N + 3) begin
            bus.in_data = VW'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        if (bus.valid_out !== 2'b11 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_stream got valid=%b busy=%b exp 11/1", bus.valid_out, bus.busy);
        end
        #2 reset = 1'b0;
        #1 check_all_zero("mid_reset");
        repeat (3) begin
            @(posedge clk); #4;
            check_all_zero("held_reset");
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #4;
        check_all_zero("after_reset");
        @(posedge clk); #1;
        run_job(4, 20, 1'b0, lat);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.num_vectors = '0;
        bus.w_valid     = 1'b0;
        bus.w_data      = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        test_reset();
        test_directed();
        test_gap();
        test_zero_vectors();
        test_start_ignored();
        test_back_to_back();
        test_max_vectors();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
